// File: rtl/sdram_phy_pkg.sv
// ----------------------------------------------------------------------------
// sdram_phy_pkg
// Shared constants for the SDRAM pad-side PHY:
//   - 4-bit command encodings over {cs,ras,cas,we} (active-low bits)
//   - legal ranges for the PHY parameters
//   - read-in-flight tracker width
//   - helper that tells whether a burst length is one the tracker supports
// ----------------------------------------------------------------------------
package sdram_phy_pkg;

   localparam int RD_CNT_W = 4;

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_LMR = 4'b0000;

   localparam int CAPTURE_STAGES_MIN = 1;
   localparam int CAPTURE_STAGES_MAX = 3;
   localparam int CAS_LATENCY_MIN    = 2;
   localparam int CAS_LATENCY_MAX    = 3;

   function automatic bit burst_len_ok(input int bl);
      return (bl == 1) || (bl == 2) || (bl == 4) || (bl == 8);
   endfunction

endpackage

// File: rtl/sdram_axi_phy_if.sv
// ----------------------------------------------------------------------------
// sdram_axi_phy_if
// Core-side bundle between the SDRAM controller core and the pad PHY.
//   cke, cs, ras, cas, we : command bits (cs..we active-low)
//   dqm[3:0]              : byte masks
//   addr[13:0], ba[1:0]   : address / bank
//   data_output[32:0]     : write data, only [31:0] reaches the pads
//   data_out_en           : core asks to drive DQ
//   data_input[31:0]      : captured read data back to the core
// Modports: master = controller core, slave = PHY.
// ----------------------------------------------------------------------------
interface sdram_axi_phy_if;
   logic        cke;
   logic        cs;
   logic        ras;
   logic        cas;
   logic        we;
   logic [3:0]  dqm;
   logic [13:0] addr;
   logic [1:0]  ba;
   logic [32:0] data_output;
   logic        data_out_en;
   logic [31:0] data_input;

   modport master (
      output cke, cs, ras, cas, we, dqm, addr, ba, data_output, data_out_en,
      input  data_input
   );

   modport slave (
      input  cke, cs, ras, cas, we, dqm, addr, ba, data_output, data_out_en,
      output data_input
   );
endinterface

// File: rtl/sdram_phy_delay.sv
// ----------------------------------------------------------------------------
// sdram_phy_delay
// N-stage, W-bit register pipeline with asynchronous active-high reset.
// Ports:
//   clk_i, rst_i : clock / async reset (clears every stage)
//   d_i[W-1:0]   : input sample
//   q_o[W-1:0]   : input delayed by exactly N clocks
// ----------------------------------------------------------------------------
module sdram_phy_delay #(
   parameter int N = 1,
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [N-1:0][W-1:0] r_pipe;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= d_i;
         for (int i = 1; i < N; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign q_o = r_pipe[N-1];

endmodule

// File: rtl/sdram_axi_phy.sv
// ----------------------------------------------------------------------------
// sdram_axi_phy
// Pad-side stage downstream of the SDRAM controller core.
//   - Registers command/address/DQM/DQ to the pads (1-cycle latency).
//   - Owns the DQ output enable; a drive request is suppressed while read
//     data may still be returning, and a sticky conflict flag is raised.
//   - Returns pad read data to the core through CAPTURE_STAGES flops.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   core (slave)       : core-side command/data bundle (sdram_axi_phy_if)
//   sdram_*_o          : registered pad outputs, sdram_dq_oe_o = DQ enable
//   sdram_dq_i         : pad read data
//   bus_conflict_o     : sticky, set when a drive is blocked by reads in flight
//   stat_*_o           : command counters, present only when the
//                        SDRAM_PHY_STATS_EN macro is defined
// ----------------------------------------------------------------------------
module sdram_axi_phy
   import sdram_phy_pkg::*;
#(
   parameter int CAPTURE_STAGES = 1,
   parameter int CAS_LATENCY    = 2,
   parameter int BURST_LEN      = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   sdram_axi_phy_if.slave         core,
   output logic                   sdram_cke_o,
   output logic                   sdram_cs_o,
   output logic                   sdram_ras_o,
   output logic                   sdram_cas_o,
   output logic                   sdram_we_o,
   output logic [3:0]             sdram_dqm_o,
   output logic [13:0]            sdram_addr_o,
   output logic [1:0]             sdram_ba_o,
   output logic [31:0]            sdram_dq_o,
   output logic                   sdram_dq_oe_o,
   input  logic [31:0]            sdram_dq_i,
`ifdef SDRAM_PHY_STATS_EN
   output logic [31:0]            stat_act_o,
   output logic [31:0]            stat_rd_o,
   output logic [31:0]            stat_wr_o,
   output logic [31:0]            stat_ref_o,
`endif
   output logic                   bus_conflict_o
);

   // Out-of-range parameters are pulled back into the supported range so
   // the tracker and capture path always elaborate to something sane.
   localparam int CS_EFF = (CAPTURE_STAGES < CAPTURE_STAGES_MIN) ? CAPTURE_STAGES_MIN :
                           (CAPTURE_STAGES > CAPTURE_STAGES_MAX) ? CAPTURE_STAGES_MAX :
                           CAPTURE_STAGES;
   localparam int CL_EFF = (CAS_LATENCY < CAS_LATENCY_MIN) ? CAS_LATENCY_MIN :
                           (CAS_LATENCY > CAS_LATENCY_MAX) ? CAS_LATENCY_MAX :
                           CAS_LATENCY;
   localparam int BL_EFF = burst_len_ok(BURST_LEN) ? BURST_LEN : 1;

   localparam logic [RD_CNT_W-1:0] RD_LOAD = RD_CNT_W'(CL_EFF + BL_EFF);
   localparam logic [RD_CNT_W-1:0] RD_ONE  = RD_CNT_W'(1);

   logic [3:0]          w_cmd;
   logic                w_is_rd;
   logic                w_block;
   logic [RD_CNT_W-1:0] r_rd_cnt;
   logic                r_conflict;
   logic                w_unused;

   assign w_cmd    = {core.cs, core.ras, core.cas, core.we};
   assign w_is_rd  = (w_cmd == CMD_RD);
   // Uses the pre-load count, so an RD and a drive request in the same
   // cycle are judged against reads already in flight, not the new one.
   assign w_block  = (r_rd_cnt != '0);
   assign w_unused = core.data_output[32];

   // Pad output flops
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sdram_cke_o   <= 1'b0;
         sdram_cs_o    <= 1'b1;
         sdram_ras_o   <= 1'b1;
         sdram_cas_o   <= 1'b1;
         sdram_we_o    <= 1'b1;
         sdram_dqm_o   <= 4'hF;
         sdram_addr_o  <= '0;
         sdram_ba_o    <= '0;
         sdram_dq_o    <= '0;
         sdram_dq_oe_o <= 1'b0;
      end else begin
         sdram_cke_o   <= core.cke;
         sdram_cs_o    <= core.cs;
         sdram_ras_o   <= core.ras;
         sdram_cas_o   <= core.cas;
         sdram_we_o    <= core.we;
         sdram_dqm_o   <= core.dqm;
         sdram_addr_o  <= core.addr;
         sdram_ba_o    <= core.ba;
         sdram_dq_o    <= core.data_output[31:0];
         sdram_dq_oe_o <= core.data_out_en & ~w_block;
      end
   end

   // Read-in-flight tracker: a new RD restarts the window rather than
   // extending it, since the latest burst is always the last to return.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rd_cnt <= '0;
      end else if (w_is_rd) begin
         r_rd_cnt <= RD_LOAD;
      end else if (w_block) begin
         r_rd_cnt <= r_rd_cnt - RD_ONE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_conflict <= 1'b0;
      end else if (core.data_out_en && w_block) begin
         r_conflict <= 1'b1;
      end
   end

   assign bus_conflict_o = r_conflict;

   // Read capture path
   sdram_phy_delay #(
      .N (CS_EFF),
      .W (32)
   ) u_capture (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (sdram_dq_i),
      .q_o   (core.data_input)
   );

`ifdef SDRAM_PHY_STATS_EN
   logic [31:0] r_stat_act;
   logic [31:0] r_stat_rd;
   logic [31:0] r_stat_wr;
   logic [31:0] r_stat_ref;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stat_act <= '0;
         r_stat_rd  <= '0;
         r_stat_wr  <= '0;
         r_stat_ref <= '0;
      end else begin
         case (w_cmd)
            CMD_ACT: r_stat_act <= r_stat_act + 32'd1;
            CMD_RD:  r_stat_rd  <= r_stat_rd  + 32'd1;
            CMD_WR:  r_stat_wr  <= r_stat_wr  + 32'd1;
            CMD_REF: r_stat_ref <= r_stat_ref + 32'd1;
            default: ;
         endcase
      end
   end

   assign stat_act_o = r_stat_act;
   assign stat_rd_o  = r_stat_rd;
   assign stat_wr_o  = r_stat_wr;
   assign stat_ref_o = r_stat_ref;
`endif

endmodule

// File: tb/tb_sdram_axi_phy.sv
`timescale 1ns/1ps
module tb_sdram_axi_phy;
   import sdram_phy_pkg::*;

   localparam int CS_N = 1;
   localparam int CL   = 2;
   localparam int BL   = 1;
   localparam int LOAD = CL + BL;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sdram_axi_phy_if core_if();

   logic [31:0] dq_i;
   logic        p_cke, p_cs, p_ras, p_cas, p_we, p_oe, conflict;
   logic [3:0]  p_dqm;
   logic [13:0] p_addr;
   logic [1:0]  p_ba;
   logic [31:0] p_dq;
`ifdef SDRAM_PHY_STATS_EN
   logic [31:0] s_act, s_rd, s_wr, s_ref;
`endif

   sdram_axi_phy #(
      .CAPTURE_STAGES (CS_N),
      .CAS_LATENCY    (CL),
      .BURST_LEN      (BL)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .core           (core_if),
      .sdram_cke_o    (p_cke),
      .sdram_cs_o     (p_cs),
      .sdram_ras_o    (p_ras),
      .sdram_cas_o    (p_cas),
      .sdram_we_o     (p_we),
      .sdram_dqm_o    (p_dqm),
      .sdram_addr_o   (p_addr),
      .sdram_ba_o     (p_ba),
      .sdram_dq_o     (p_dq),
      .sdram_dq_oe_o  (p_oe),
      .sdram_dq_i     (dq_i),
`ifdef SDRAM_PHY_STATS_EN
      .stat_act_o     (s_act),
      .stat_rd_o      (s_rd),
      .stat_wr_o      (s_wr),
      .stat_ref_o     (s_ref),
`endif
      .bus_conflict_o (conflict)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: what the pads/core must show after the next edge.
   // Drive blocking: an edge is blocked if the last RD was seen within
   // LOAD edges before it. Capture path is a queue of CS_N samples.
   // ------------------------------------------------------------------
   logic        m_cke, m_oe, m_conf;
   logic [3:0]  m_cmd, m_dqm;
   logic [13:0] m_addr;
   logic [1:0]  m_ba;
   logic [31:0] m_dq, m_cap;
   int          m_edge, m_last_rd;
   logic [31:0] m_capq[$];
   logic [31:0] m_act, m_rd, m_wr, m_ref;

   task automatic model_reset();
      m_cke = 0; m_cmd = 4'hF; m_dqm = 4'hF; m_addr = 0; m_ba = 0;
      m_dq = 0; m_oe = 0; m_conf = 0; m_cap = 0;
      m_edge = 0; m_last_rd = -1000;
      m_capq.delete();
      for (int i = 0; i < CS_N; i++) m_capq.push_back(32'h0);
      m_act = 0; m_rd = 0; m_wr = 0; m_ref = 0;
   endtask

   task automatic model_step();
      logic [3:0] c;
      bit blk;
      c = {core_if.cs, core_if.ras, core_if.cas, core_if.we};
      m_edge++;
      blk = (m_edge - m_last_rd) <= LOAD;
      m_cke = core_if.cke; m_cmd = c; m_dqm = core_if.dqm;
      m_addr = core_if.addr; m_ba = core_if.ba; m_dq = core_if.data_output[31:0];
      m_oe = core_if.data_out_en && !blk;
      if (core_if.data_out_en && blk) m_conf = 1;
      if (c == CMD_RD) m_last_rd = m_edge;
      m_capq.push_back(dq_i);
      void'(m_capq.pop_front());
      m_cap = m_capq[0];
      if (c == CMD_ACT) m_act++;
      if (c == CMD_RD)  m_rd++;
      if (c == CMD_WR)  m_wr++;
      if (c == CMD_REF) m_ref++;
   endtask

   // Compare process: inputs only change just after a rising edge, so at
   // the falling edge the outputs reflect the inputs sampled last time.
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (rst) model_reset();
         chk("cke",  {63'b0, p_cke}, {63'b0, m_cke});
         chk("cmd",  {60'b0, p_cs, p_ras, p_cas, p_we}, {60'b0, m_cmd});
         chk("dqm",  {60'b0, p_dqm}, {60'b0, m_dqm});
         chk("addr", {50'b0, p_addr}, {50'b0, m_addr});
         chk("ba",   {62'b0, p_ba}, {62'b0, m_ba});
         chk("dq_o", {32'b0, p_dq}, {32'b0, m_dq});
         chk("dq_oe", {63'b0, p_oe}, {63'b0, m_oe});
         chk("conflict", {63'b0, conflict}, {63'b0, m_conf});
         chk("rd_data", {32'b0, core_if.data_input}, {32'b0, m_cap});
`ifdef SDRAM_PHY_STATS_EN
         chk("stat_act", {32'b0, s_act}, {32'b0, m_act});
         chk("stat_rd",  {32'b0, s_rd},  {32'b0, m_rd});
         chk("stat_wr",  {32'b0, s_wr},  {32'b0, m_wr});
         chk("stat_ref", {32'b0, s_ref}, {32'b0, m_ref});
`endif
         if (!rst) model_step();
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic [3:0] c);
      {core_if.cs, core_if.ras, core_if.cas, core_if.we} = c;
   endtask

   task automatic idle();
      set_cmd(CMD_NOP);
      core_if.cs = 1'b1;
      core_if.dqm = 4'hF;
      core_if.addr = '0;
      core_if.ba = '0;
      core_if.data_output = '0;
      core_if.data_out_en = 1'b0;
      dq_i = '0;
   endtask

   initial begin
      logic [3:0] c;
      core_if.cke = 1'b0;
      idle();
      repeat (3) cyc();
      rst = 1'b0;

      // reset state with idle core
      @(negedge clk);
      chk("lit_rst_cke", {63'b0, p_cke}, 64'h0);
      chk("lit_rst_cs",  {63'b0, p_cs}, 64'h1);
      chk("lit_rst_dqm", {60'b0, p_dqm}, 64'hF);
      chk("lit_rst_oe",  {63'b0, p_oe}, 64'h0);
      chk("lit_rst_rd",  {32'b0, core_if.data_input}, 64'h0);

      // first core change appears exactly one edge later
      cyc();
      core_if.cke = 1'b1;
      @(negedge clk);
      chk("lit_cke_pre", {63'b0, p_cke}, 64'h0);
      @(negedge clk);
      chk("lit_cke_post", {63'b0, p_cke}, 64'h1);

      // ACT then RD on bank 2 / addr 0x40, read data back after capture
      cyc();
      set_cmd(CMD_ACT); core_if.ba = 2'd2; core_if.addr = 14'h0040; core_if.dqm = 4'h0;
      cyc();
      set_cmd(CMD_RD);
      @(negedge clk);
      chk("lit_act_cmd", {60'b0, p_cs, p_ras, p_cas, p_we}, 64'h3);
      chk("lit_act_ba",  {62'b0, p_ba}, 64'h2);
      cyc();
      set_cmd(CMD_NOP);
      @(negedge clk);
      chk("lit_rd_cmd",  {60'b0, p_cs, p_ras, p_cas, p_we}, 64'h5);
      chk("lit_rd_addr", {50'b0, p_addr}, 64'h40);
      cyc();
      cyc();
      cyc();
      dq_i = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      chk("lit_rd_data", {32'b0, core_if.data_input}, 64'hDEADBEEF);
      chk("lit_rd_noconf", {63'b0, conflict}, 64'h0);

      // write: bit 32 must not reach the pads
      cyc();
      dq_i = '0;
      set_cmd(CMD_WR); core_if.data_output = 33'h1_12345678; core_if.data_out_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("lit_wr_dq", {32'b0, p_dq}, 64'h12345678);
      chk("lit_wr_oe", {63'b0, p_oe}, 64'h1);

      // drive request inside the read window
      cyc();
      set_cmd(CMD_RD); core_if.data_out_en = 1'b0;
      cyc();
      set_cmd(CMD_NOP);
      cyc();
      core_if.data_out_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("lit_blk_oe", {63'b0, p_oe}, 64'h0);
      chk("lit_blk_conf", {63'b0, conflict}, 64'h1);
      cyc();
      core_if.data_out_en = 1'b0;
      repeat (100) cyc();
      @(negedge clk);
      chk("lit_conf_sticky", {63'b0, conflict}, 64'h1);

      // async reset while driving
      cyc();
      set_cmd(CMD_WR); core_if.data_out_en = 1'b1; core_if.data_output = 33'h0_A5A5A5A5;
      @(posedge clk);
      @(negedge clk);
      chk("lit_pre_rst_oe", {63'b0, p_oe}, 64'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("lit_arst_oe",   {63'b0, p_oe}, 64'h0);
      chk("lit_arst_cke",  {63'b0, p_cke}, 64'h0);
      chk("lit_arst_cs",   {63'b0, p_cs}, 64'h1);
      chk("lit_arst_conf", {63'b0, conflict}, 64'h0);
      cyc();
      idle();
      cyc();
      rst = 1'b0;

      // randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         cyc();
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
         end
         case ($urandom_range(0, 9))
            0, 1:    c = CMD_NOP;
            2:       c = CMD_ACT;
            3, 4:    c = CMD_RD;
            5:       c = CMD_WR;
            6:       c = CMD_PRE;
            7:       c = CMD_REF;
            8:       c = CMD_LMR;
            default: c = {1'b1, 3'($urandom_range(0, 7))};
         endcase
         set_cmd(c);
         core_if.cke = ($urandom_range(0, 15) != 0);
         core_if.dqm = 4'($urandom_range(0, 15));
         core_if.addr = 14'($urandom);
         core_if.ba = 2'($urandom_range(0, 3));
         core_if.data_output = {1'($urandom_range(0, 1)), 32'($urandom)};
         core_if.data_out_en = ($urandom_range(0, 3) == 0);
         dq_i = 32'($urandom);
      end
      cyc();
      rst = 1'b0;
      idle();
      repeat (3) cyc();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
